fib_responder: RTL and testbench
================================

FIB_RESPONDER -- requirements
Module: fib_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of n_i and result_o.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port strobe_i  input  1  request strobe; a request is its 0->1 transition as sampled on clk.
REQ-005 SHALL have port n_i  input  WIDTH  Fibonacci index, sampled on the accept edge.
REQ-006 SHALL have port result_o  output  WIDTH  F(n) mod 2^WIDTH, held until the next completion.
REQ-007 SHALL have port busy_o  output  1  high while a request is being computed.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse on completion.
REQ-009 SHALL have port ovf_o  output  1  sticky flag, set if any addition of the current request carried out of WIDTH bits.

Function
REQ-010 SHALL register strobe_i once (strobe_q) and detect a request as strobe_i=1 with strobe_q=0.
REQ-011 SHALL implement a two-state FSM: IDLE and CALC.
REQ-012 SHALL accept a request only when the state is IDLE at the sampling edge; an accept loads cnt<=n_i, a<=0, b<=1, ovf_o<=0, busy_o<=1, and moves to CALC.
REQ-013 SHALL ignore, and not queue, requests that arrive while in CALC, including one on the edge where CALC exits.
REQ-014 SHALL, in CALC with cnt>=2: set b<=a+b (truncated to WIDTH), a<=b, cnt<=cnt-1, and ovf_o<=ovf_o|carry.
REQ-015 SHALL, in CALC with cnt<=1: set result_o<=(cnt==0 ? 0 : b), busy_o<=0, done_o<=1 for one cycle, and return to IDLE.
REQ-016 SHALL keep busy_o high for exactly max(n,1) cycles; result_o and done_o are valid on the cycle after busy_o falls.
REQ-017 SHALL leave result_o and ovf_o unchanged from completion until the next completion or accept (ovf_o clears on accept).
REQ-018 SHALL treat a strobe_i held high continuously as a single request; a new request requires strobe_i to return to 0.
REQ-019 SHALL start a new request on the cycle after done_o if a fresh rising edge of strobe_i arrives there.
REQ-020 SHALL use mod-2^WIDTH arithmetic; n=255 with WIDTH=8 completes in 255 busy cycles.

Reset
REQ-021 SHALL, on rst high, asynchronously force state=IDLE and strobe_q=0.
REQ-022 SHALL, on rst high, asynchronously force result_o=0, busy_o=0, done_o=0, ovf_o=0, cnt=0, a=0, b=1.
REQ-023 SHALL abort any computation when rst is asserted mid-CALC, produce no done_o, and require a new strobe after rst is released.

Structure
REQ-024 SHALL place the state enum (IDLE, CALC) and the default WIDTH constant in shared package fib_pkg.
REQ-025 SHALL implement the rising-edge detector as a sub-module, strobe_edge_det, with the same clk and rst ports.
REQ-026 SHALL keep the datapath (a, b, cnt, adder with carry-out) in fib_responder itself.

Verification
REQ-027 Bench SHALL check: reset, then n=0..10 each via a one-cycle strobe -> result_o = 0,1,1,2,3,5,8,13,21,34,55; busy_o width max(n,1); one done_o pulse per request.
REQ-028 Bench SHALL check: n=13 -> result_o=233 with ovf_o=0; n=14 -> result_o=121 with ovf_o=1.
REQ-029 Bench SHALL check: strobe_i held high for 20 cycles with n=5 -> exactly one done_o and result_o=5.
REQ-030 Bench SHALL check: n=10 request followed by a second strobe (n=3) mid-CALC -> the second is ignored and result_o=55 with a single done_o.
REQ-031 Bench SHALL check: n=20 request with rst pulsed at busy cycle 7 -> busy_o=0, result_o=0, ovf_o=0 immediately with no done_o; a following n=6 request -> result_o=8.
REQ-032 Bench SHALL check: back-to-back requests with the strobe edge on the cycle after done_o (n=4 then n=7) -> result_o=3, then 13, with no lost request.

Source files
------------

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci responder
package fib_pkg;

    localparam int FIB_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } fib_state_t;

endpackage

// File: rtl/strobe_edge_det.sv
// rtl/strobe_edge_det.sv - registers the request strobe and flags its 0->1 transition
module strobe_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    output logic rise_o
);

    logic r_strobe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= strobe_i;
        end
    end

    assign rise_o = strobe_i & ~r_strobe_q;

endmodule

// File: rtl/fib_responder.sv
// rtl/fib_responder.sv - iterative F(n) mod 2^WIDTH on a strobe edge, with busy/done/overflow
module fib_responder
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fib_state_t       r_state;
    fib_state_t       w_next_state;
    logic             w_req;
    logic             w_accept;
    logic             w_step;
    logic             w_finish;
    logic             w_cnt_le1;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    strobe_edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (strobe_i),
        .rise_o   (w_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_cnt_le1 = (r_cnt[WIDTH-1:1] == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next_state = CALC;
            CALC:    if (w_cnt_le1) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Requests seen while in CALC are dropped; the edge detector still tracks the strobe.
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE:    w_accept = w_req;
            CALC:    begin
                w_step   = ~w_cnt_le1;
                w_finish = w_cnt_le1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= ONE;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt  <= n_i;
                r_a    <= '0;
                r_b    <= ONE;
                r_ovf  <= 1'b0;
                r_busy <= 1'b1;
            end else if (w_step) begin
                r_b   <= w_sum[WIDTH-1:0];
                r_a   <= r_b;
                r_cnt <= r_cnt - ONE;
                r_ovf <= r_ovf | w_sum[WIDTH];
            end else if (w_finish) begin
                // cnt is 0 or 1 here: F(0)=0, otherwise b already holds F(n)
                r_result <= r_cnt[0] ? r_b : '0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign result_o = r_result;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_fib_responder.sv
// tb/tb_fib_responder.sv - self-checking bench for fib_responder against a behavioural model
module tb_fib_responder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         strobe_i;
    logic [W-1:0] n_i;
    logic [W-1:0] result_o;
    logic         busy_o;
    logic         done_o;
    logic         ovf_o;

    fib_responder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (strobe_i),
        .n_i      (n_i),
        .result_o (result_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plain Fibonacci: residue mod 2^W, and whether the true value ever reached 2^W.
    function automatic void fib_ref(input int n, output int r, output int ov);
        int     x = 0;
        int     y = 1;
        int     t;
        longint tx = 0;
        longint ty = 1;
        longint tt;
        for (int k = 0; k < n; k++) begin
            t  = (x + y) % (1 << W);
            x  = y;
            y  = t;
            tt = tx + ty;
            if (tt > 1000000) tt = 1000000;
            tx = ty;
            ty = tt;
        end
        r  = x;
        ov = (tx >= (1 << W)) ? 1 : 0;
    endfunction

    // Behavioural model: request = strobe rise; busy lasts max(n,1) cycles; then a done pulse.
    int m_left;
    int m_res;
    int m_ovf;
    int m_pend_res;
    int m_pend_ovf;
    bit m_done;
    bit m_prev;
    bit m_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_res = 0; m_ovf = 0; m_done = 1'b0; m_prev = 1'b0;
        end else begin
            m_req  = strobe_i && !m_prev;
            m_prev = strobe_i;
            m_done = 1'b0;
            if (m_left == 0) begin
                if (m_req) begin
                    m_left = (n_i == 0) ? 1 : int'(n_i);
                    fib_ref(int'(n_i), m_pend_res, m_pend_ovf);
                    m_ovf = 0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend_res;
                    m_ovf  = m_pend_ovf;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (chk_en && !rst) begin
            check("cyc_busy", busy_o, (m_left > 0) ? 1 : 0);
            check("cyc_done", done_o, m_done);
            check("cyc_result", result_o, m_res);
            if (m_left == 0) check("cyc_ovf", ovf_o, m_ovf);
        end
    end

    task automatic pulse(input int n, input int hold);
        @(negedge clk);
        n_i = W'(n);
        strobe_i = 1'b1;
        repeat (hold) @(negedge clk);
        strobe_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (busy_o) busy_cycles++;
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_req(input string tag, input int n, input int exp_res, input int exp_ovf);
        int bc;
        bit ok;
        int d0;
        d0 = done_cnt;
        pulse(n, 1);
        wait_done(400, bc, ok);
        check({tag, "_done_seen"}, ok, 1);
        check({tag, "_busy_width"}, bc, (n == 0) ? 1 : n);
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_ovf"}, ovf_o, exp_ovf);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fib_lit[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        int r, ov, bc, d0;
        bit ok;

        fib_ref(10, r, ov);  check("model_f10", r, 55);
        fib_ref(13, r, ov);  check("model_f13", r, 233); check("model_f13_ovf", ov, 0);
        fib_ref(14, r, ov);  check("model_f14", r, 121); check("model_f14_ovf", ov, 1);

        rst = 1'b1; strobe_i = 1'b0; n_i = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", ovf_o, 0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        for (int n = 0; n <= 10; n++) do_req($sformatf("n%0d", n), n, fib_lit[n], 0);
        do_req("n13", 13, 233, 0);
        do_req("n14", 14, 121, 1);

        // strobe held for 20 cycles counts once
        d0 = done_cnt;
        @(negedge clk); n_i = 8'd5; strobe_i = 1'b1;
        wait_done(100, bc, ok);
        check("held_done_seen", ok, 1);
        repeat (14) @(negedge clk);
        strobe_i = 1'b0;
        repeat (5) @(negedge clk);
        check("held_done_count", done_cnt - d0, 1);
        check("held_result", result_o, 5);

        // second strobe during CALC is ignored
        d0 = done_cnt;
        pulse(10, 1);
        repeat (3) @(negedge clk);
        n_i = 8'd3; strobe_i = 1'b1;
        @(negedge clk); strobe_i = 1'b0;
        wait_done(100, bc, ok);
        check("midcalc_done_seen", ok, 1);
        check("midcalc_result", result_o, 55);
        repeat (8) @(negedge clk);
        check("midcalc_done_count", done_cnt - d0, 1);

        // reset at busy cycle 7 of an n=20 request
        pulse(20, 1);
        repeat (6) @(negedge clk);
        check("prerst_busy", busy_o, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_result", result_o, 0);
        check("abort_ovf", ovf_o, 0);
        check("abort_done", done_o, 0);
        d0 = done_cnt;
        @(negedge clk); #1 rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        do_req("after_rst_n6", 6, 8, 0);

        // back-to-back: new strobe edge on the done cycle
        d0 = done_cnt;
        pulse(4, 1);
        wait_done(100, bc, ok);
        check("b2b_first_seen", ok, 1);
        check("b2b_first_result", result_o, 3);
        n_i = 8'd7; strobe_i = 1'b1;
        @(negedge clk); strobe_i = 1'b0;
        wait_done(100, bc, ok);
        check("b2b_second_seen", ok, 1);
        check("b2b_second_busy", bc, 7);
        check("b2b_second_result", result_o, 13);
        repeat (3) @(negedge clk);
        check("b2b_done_count", done_cnt - d0, 2);

        // longest request
        fib_ref(255, r, ov);
        do_req("n255", 255, r, ov);

        // random strobes and indices, checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            strobe_i = 1'($urandom_range(0, 1));
            n_i = W'($urandom_range(0, 24));
        end
        strobe_i = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
